// File: rtl/text_line_drawer.sv
// Line sequencer: walks a glyph buffer and issues one symbol-drawer job
// per glyph, with per-glyph x offset and cursor flags.
module text_line_drawer #(
  parameter int MAX_LENGTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int SYMBOL_PITCH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_write_enable,
  input  logic [ADDR_WIDTH-1:0] buf_write_addr,
  input  logic [15:0]           buf_write_data,
  input  logic                  line_start,
  input  logic [15:0]           line_x,
  input  logic [15:0]           line_y,
  input  logic [ADDR_WIDTH:0]   line_length,
  input  logic [ADDR_WIDTH:0]   line_cursor,
  output logic                  line_ready,
  output logic                  line_done,
  output logic                  symbol_drawer_start,
  input  logic                  symbol_drawer_ready,
  output logic [15:0]           symbol_drawer_x,
  output logic [15:0]           symbol_drawer_y,
  output logic [15:0]           symbol_drawer_symbol,
  output logic                  symbol_drawer_cursor_left,
  output logic                  symbol_drawer_cursor_right
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(MAX_LENGTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
  localparam logic [15:0] PITCH = 16'(SYMBOL_PITCH);

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  logic [ADDR_WIDTH:0] cur_q, cur_d;
  logic [15:0] lx_q, lx_d;
  logic [15:0] ly_q, ly_d;
  logic [15:0] ox_q, ox_d;
  logic [15:0] oy_q, oy_d;
  logic [15:0] osym_q, osym_d;
  logic ocl_q, ocl_d;
  logic ocr_q, ocr_d;
  logic done_q, done_d;

  logic [15:0] buf_mem_q [MAX_LENGTH];

  logic [ADDR_WIDTH:0] len_clamped;
  logic [ADDR_WIDTH:0] index_ext;
  logic [15:0] x_calc;
  logic last;

  // Buffer is plain storage: no reset, writable in every state.
  always_ff @(posedge clk) begin
    if (buf_write_enable) begin
      buf_mem_q[buf_write_addr] <= buf_write_data;
    end
  end

  always_comb begin
    len_clamped = (line_length > LEN_MAX) ? LEN_MAX : line_length;
    index_ext = {1'b0, index_q};
    last = (index_ext == (len_q - LEN_ONE));
    x_calc = lx_q + (16'(index_q) * PITCH);
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d = len_q;
    cur_d = cur_q;
    lx_d = lx_q;
    ly_d = ly_q;
    ox_d = ox_q;
    oy_d = oy_q;
    osym_d = osym_q;
    ocl_d = ocl_q;
    ocr_d = ocr_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (line_start) begin
          lx_d = line_x;
          ly_d = line_y;
          cur_d = line_cursor;
          len_d = len_clamped;
          index_d = '0;
          if (len_clamped == LEN_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ox_d = x_calc;
        oy_d = ly_q;
        osym_d = buf_mem_q[index_q];
        ocl_d = (cur_q == index_ext);
        ocr_d = last && (cur_q == len_q);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (symbol_drawer_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (symbol_drawer_ready) begin
          if (last) begin
            done_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      len_q <= '0;
      cur_q <= '0;
      lx_q <= '0;
      ly_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      osym_q <= '0;
      ocl_q <= 1'b0;
      ocr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q <= len_d;
      cur_q <= cur_d;
      lx_q <= lx_d;
      ly_q <= ly_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      osym_q <= osym_d;
      ocl_q <= ocl_d;
      ocr_q <= ocr_d;
      done_q <= done_d;
    end
  end

  // Start gates on the drawer's ready and the async-reset state.
  assign symbol_drawer_start = (state_q == S_ISSUE) && symbol_drawer_ready;
  assign line_ready = (state_q == S_IDLE);
  assign line_done = done_q;
  assign symbol_drawer_x = ox_q;
  assign symbol_drawer_y = oy_q;
  assign symbol_drawer_symbol = osym_q;
  assign symbol_drawer_cursor_left = ocl_q;
  assign symbol_drawer_cursor_right = ocr_q;

endmodule

// File: tb/tb_text_line_drawer.sv
// Directed bench for text_line_drawer with a behavioural
// symbol-drawer model that stays busy for a fixed number of cycles.
module tb_text_line_drawer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic buf_write_enable = 1'b0;
  logic [4:0] buf_write_addr = '0;
  logic [15:0] buf_write_data = '0;
  logic line_start = 1'b0;
  logic [15:0] line_x = '0;
  logic [15:0] line_y = '0;
  logic [5:0] line_length = '0;
  logic [5:0] line_cursor = '0;
  logic line_ready;
  logic line_done;
  logic symbol_drawer_start;
  logic drv_ready = 1'b1;
  logic [15:0] symbol_drawer_x;
  logic [15:0] symbol_drawer_y;
  logic [15:0] symbol_drawer_symbol;
  logic symbol_drawer_cursor_left;
  logic symbol_drawer_cursor_right;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  text_line_drawer #(
    .MAX_LENGTH(32),
    .ADDR_WIDTH(5),
    .SYMBOL_PITCH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buf_write_enable(buf_write_enable),
    .buf_write_addr(buf_write_addr),
    .buf_write_data(buf_write_data),
    .line_start(line_start),
    .line_x(line_x),
    .line_y(line_y),
    .line_length(line_length),
    .line_cursor(line_cursor),
    .line_ready(line_ready),
    .line_done(line_done),
    .symbol_drawer_start(symbol_drawer_start),
    .symbol_drawer_ready(drv_ready),
    .symbol_drawer_x(symbol_drawer_x),
    .symbol_drawer_y(symbol_drawer_y),
    .symbol_drawer_symbol(symbol_drawer_symbol),
    .symbol_drawer_cursor_left(symbol_drawer_cursor_left),
    .symbol_drawer_cursor_right(symbol_drawer_cursor_right)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Drawer model: never reset, so a job survives a DUT reset.
  int busy = 0;
  int busy_len = 5;
  bit force_busy = 1'b0;
  always @(posedge clk) begin
    if (symbol_drawer_start) begin
      busy <= busy_len;
      drv_ready <= 1'b0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy <= 0;
      drv_ready <= !force_busy;
    end else begin
      drv_ready <= !force_busy;
    end
  end

  int n = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int viol = 0;
  int ready_low = 0;
  logic [15:0] jx [64];
  logic [15:0] jy [64];
  logic [15:0] js [64];
  logic jl [64];
  logic jr [64];
  int jc [64];

  always @(negedge clk) begin
    if (symbol_drawer_start) begin
      if (n < 64) begin
        jx[n] = symbol_drawer_x;
        jy[n] = symbol_drawer_y;
        js[n] = symbol_drawer_symbol;
        jl[n] = symbol_drawer_cursor_left;
        jr[n] = symbol_drawer_cursor_right;
        jc[n] = cyc;
      end
      if (!drv_ready) viol++;
      n++;
    end
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!line_ready) ready_low++;
  end

  task automatic clear_mon();
    @(posedge clk);
    n = 0;
    done_cnt = 0;
    viol = 0;
    ready_low = 0;
    @(negedge clk);
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    buf_write_enable = 1'b1;
    buf_write_addr = a;
    buf_write_data = d;
    @(negedge clk);
    buf_write_enable = 1'b0;
  endtask

  task automatic send_line(input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] len, input logic [5:0] cur,
                           output int s_cyc);
    @(negedge clk);
    line_x = x;
    line_y = y;
    line_length = len;
    line_cursor = cur;
    line_start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (line_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (line_ready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_ready got %b want 1", line_ready);
    end
    cmp_cnt++;
    if ({line_done, symbol_drawer_start} !== 2'b00) begin
      err_cnt++; $display("FAIL reset_done_start got %b want 00",
                          {line_done, symbol_drawer_start});
    end
    cmp_cnt++;
    if ({symbol_drawer_x, symbol_drawer_y, symbol_drawer_symbol} !== 48'h0) begin
      err_cnt++; $display("FAIL reset_operands got %h want 0",
        {symbol_drawer_x, symbol_drawer_y, symbol_drawer_symbol});
    end
    cmp_cnt++;
    if ({symbol_drawer_cursor_left, symbol_drawer_cursor_right} !== 2'b00) begin
      err_cnt++; $display("FAIL reset_flags got %b want 00",
        {symbol_drawer_cursor_left, symbol_drawer_cursor_right});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    logic [15:0] ex [3];
    logic [15:0] es [3];
    ex[0] = 16'd100; ex[1] = 16'd108; ex[2] = 16'd116;
    es[0] = 16'h41; es[1] = 16'h42; es[2] = 16'h43;
    write_buf(5'd0, 16'h41);
    write_buf(5'd1, 16'h42);
    write_buf(5'd2, 16'h43);
    clear_mon();
    send_line(16'd100, 16'd20, 6'd3, 6'd1, s);
    wait_done(200, ok);
    cmp_cnt++;
    if (!ok) begin
      err_cnt++; $display("FAIL basic_timeout got 0 want 1");
    end
    repeat (20) @(negedge clk);
    cmp_cnt++;
    if (n !== 3) begin
      err_cnt++; $display("FAIL basic_jobs got %0d want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if ({jx[i], jy[i], js[i]} !== {ex[i], 16'd20, es[i]}) begin
        err_cnt++; $display("FAIL basic_job%0d got %h want %h", i,
          {jx[i], jy[i], js[i]}, {ex[i], 16'd20, es[i]});
      end
      cmp_cnt++;
      if ({jl[i], jr[i]} !== {(i == 1), 1'b0}) begin
        err_cnt++; $display("FAIL basic_flags%0d got %b want %b", i,
          {jl[i], jr[i]}, {(i == 1), 1'b0});
      end
    end
    cmp_cnt++;
    if (jc[0] !== s + 2) begin
      err_cnt++; $display("FAIL basic_first_latency got %0d want %0d", jc[0], s + 2);
    end
    cmp_cnt++;
    if (jc[1] !== jc[0] + 8) begin
      err_cnt++; $display("FAIL basic_glyph_gap got %0d want %0d", jc[1], jc[0] + 8);
    end
    cmp_cnt++;
    if (done_cnt !== 1 || done_cyc !== jc[2] + 7) begin
      err_cnt++; $display("FAIL basic_done got cnt %0d cyc %0d want 1 cyc %0d",
                          done_cnt, done_cyc, jc[2] + 7);
    end
  endtask

  task automatic test_cursor_right();
    int s;
    bit ok;
    clear_mon();
    send_line(16'd0, 16'd5, 6'd2, 6'd2, s);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 2) begin
      err_cnt++; $display("FAIL cright_jobs got %0d want 2", n);
    end
    cmp_cnt++;
    if ({jl[0], jr[0], jl[1], jr[1]} !== 4'b0001) begin
      err_cnt++; $display("FAIL cright_flags got %b want 0001",
                          {jl[0], jr[0], jl[1], jr[1]});
    end
  endtask

  task automatic test_wrap();
    int s;
    bit ok;
    clear_mon();
    send_line(16'hFFFC, 16'd7, 6'd2, 6'd9, s);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 2 || {jx[0], jx[1]} !== 32'hFFFC_0004) begin
      err_cnt++; $display("FAIL wrap_x got %h want fffc0004", {jx[0], jx[1]});
    end
  endtask

  task automatic test_zero_len();
    int s;
    clear_mon();
    send_line(16'd1, 16'd1, 6'd0, 6'd0, s);
    repeat (10) @(negedge clk);
    cmp_cnt++;
    if (n !== 0 || done_cnt !== 1) begin
      err_cnt++; $display("FAIL zero_len got jobs %0d done %0d want 0 1", n, done_cnt);
    end
    cmp_cnt++;
    if (done_cyc !== s + 1) begin
      err_cnt++; $display("FAIL zero_len_done_cyc got %0d want %0d", done_cyc, s + 1);
    end
    cmp_cnt++;
    if (ready_low !== 0) begin
      err_cnt++; $display("FAIL zero_len_ready got %0d low cycles want 0", ready_low);
    end
  endtask

  task automatic test_ready_low();
    int s;
    bit ok;
    force_busy = 1'b1;
    clear_mon();
    @(negedge clk);
    send_line(16'd50, 16'd2, 6'd1, 6'd0, s);
    repeat (8) @(negedge clk);
    cmp_cnt++;
    if (n !== 0 || line_ready !== 1'b0) begin
      err_cnt++; $display("FAIL hold_issue got jobs %0d ready %b want 0 0", n, line_ready);
    end
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (4) @(negedge clk);
    force_busy = 1'b0;
    wait_done(100, ok);
    repeat (30) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 1 || done_cnt !== 1) begin
      err_cnt++; $display("FAIL hold_once got jobs %0d done %0d want 1 1", n, done_cnt);
    end
    cmp_cnt++;
    if (jl[0] !== 1'b1 || jc[0] <= s + 2) begin
      err_cnt++; $display("FAIL hold_job got cl %b cyc %0d want 1 after %0d",
                          jl[0], jc[0], s + 2);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    busy_len = 12;
    clear_mon();
    send_line(16'd10, 16'd3, 6'd3, 6'd0, s);
    for (int i = 0; i < 100 && n < 2; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({line_ready, line_done, symbol_drawer_start} !== 3'b100) begin
      err_cnt++; $display("FAIL midrst_ctrl got %b want 100",
                          {line_ready, line_done, symbol_drawer_start});
    end
    cmp_cnt++;
    if ({symbol_drawer_x, symbol_drawer_y, symbol_drawer_symbol,
         symbol_drawer_cursor_left, symbol_drawer_cursor_right} !== 50'h0) begin
      err_cnt++; $display("FAIL midrst_operands got %h want 0",
        {symbol_drawer_x, symbol_drawer_y, symbol_drawer_symbol});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    send_line(16'd30, 16'd4, 6'd1, 6'd7, s);
    wait_done(100, ok);
    repeat (15) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 1 || js[0] !== 16'h41 || jx[0] !== 16'd30) begin
      err_cnt++; $display("FAIL midrst_next got jobs %0d sym %h x %0d want 1 41 30",
                          n, js[0], jx[0]);
    end
    cmp_cnt++;
    if (viol !== 0 || jc[0] <= s + 2) begin
      err_cnt++; $display("FAIL midrst_wait got viol %0d cyc %0d want 0 after %0d",
                          viol, jc[0], s + 2);
    end
    busy_len = 5;
  endtask

  task automatic test_back_to_back();
    int s;
    bit ok;
    clear_mon();
    send_line(16'd0, 16'd0, 6'd1, 6'd9, s);
    wait_done(100, ok);
    line_x = 16'd200;
    line_length = 6'd1;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 2 || jx[1] !== 16'd200) begin
      err_cnt++; $display("FAIL b2b got jobs %0d x %0d want 2 200", n, jx[1]);
    end
  endtask

  task automatic test_late_write();
    int s;
    bit ok;
    write_buf(5'd2, 16'h43);
    clear_mon();
    send_line(16'd0, 16'd0, 6'd3, 6'd9, s);
    for (int i = 0; i < 100 && n < 1; i++) @(negedge clk);
    buf_write_enable = 1'b1;
    buf_write_addr = 5'd2;
    buf_write_data = 16'h5A;
    @(negedge clk);
    buf_write_enable = 1'b0;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 3 || js[2] !== 16'h5A || js[1] !== 16'h42) begin
      err_cnt++; $display("FAIL late_write got %h %h want 42 5a", js[1], js[2]);
    end
  endtask

  task automatic test_clamp();
    int s;
    bit ok;
    int flags;
    for (int i = 0; i < 32; i++) write_buf(5'(i), 16'h100 + 16'(i));
    clear_mon();
    send_line(16'h0200, 16'd9, 6'd33, 6'd40, s);
    wait_done(2000, ok);
    repeat (20) @(negedge clk);
    cmp_cnt++;
    if (!ok || n !== 32 || done_cnt !== 1) begin
      err_cnt++; $display("FAIL clamp_jobs got %0d done %0d want 32 1", n, done_cnt);
    end
    cmp_cnt++;
    if (js[31] !== 16'h011F || jx[31] !== 16'h02F8 || js[0] !== 16'h0100) begin
      err_cnt++; $display("FAIL clamp_last got sym %h x %h want 011f 02f8", js[31], jx[31]);
    end
    flags = 0;
    for (int i = 0; i < 32; i++) flags += int'(jl[i]) + int'(jr[i]);
    cmp_cnt++;
    if (flags !== 0) begin
      err_cnt++; $display("FAIL clamp_flags got %0d want 0", flags);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cursor_right();
    test_wrap();
    test_zero_len();
    test_ready_low();
    test_reset_mid();
    test_back_to_back();
    test_late_write();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/text_line_drawer.md
# text_line_drawer

Sequencer that renders a line of up to MAX_LENGTH glyphs through the existing symbol drawer. It holds a small glyph buffer and latches a line command (origin, length, cursor position). It then issues one symbol-drawer job per glyph, computing each glyph's x coordinate and cursor flags and waiting for completion before issuing the next. It sits between the text/editor logic and the symbol drawer, in place of per-glyph writes through the accelerator path.

## Interface

Parameters:
- MAX_LENGTH, 32: glyph buffer depth, power of two.
- ADDR_WIDTH, 5: log2(MAX_LENGTH).
- SYMBOL_PITCH, 8: horizontal pixel step between glyphs.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- buf_write_enable  in  1  write glyph buffer this cycle.
- buf_write_addr  in  ADDR_WIDTH  glyph index to write.
- buf_write_data  in  16  glyph code.
- line_start  in  1  one-cycle command strobe; honoured only while line_ready=1.
- line_x  in  16  x of glyph 0.
- line_y  in  16  y of the line.
- line_length  in  ADDR_WIDTH+1  glyph count, 0..MAX_LENGTH.
- line_cursor  in  ADDR_WIDTH+1  cursor position (gap index), 0..line_length; values above line_length mean no cursor.
- line_ready  out  1  high in IDLE.
- line_done  out  1  one-cycle pulse when the last glyph completes, or on a zero-length command.
- symbol_drawer_start  out  1  one-cycle job strobe.
- symbol_drawer_ready  in  1  drawer idle; must be low on the cycle after a start pulse it accepted.
- symbol_drawer_x, symbol_drawer_y, symbol_drawer_symbol  out  16  job operands.
- symbol_drawer_cursor_left, symbol_drawer_cursor_right  out  1  cursor flags for the job.

## Operation

- Glyph buffer: MAX_LENGTH x 16, one write port, written whenever buf_write_enable=1, in any state. Not reset; contents undefined after power-up.
- A buffer write to index i takes effect for the current line only if glyph i has not yet entered LOAD.
- States:
  - IDLE: line_ready=1. On line_start, latch x, y, cursor and length into the command registers, clamping length to MAX_LENGTH. Set index=0. If the clamped length is 0, pulse line_done and stay in IDLE; otherwise go to LOAD.
  - LOAD: register the job operands, then go to ISSUE.
    - symbol_drawer_x = x_latched + index*SYMBOL_PITCH, 16-bit result, wraps modulo 2^16.
    - symbol_drawer_y = y_latched.
    - symbol_drawer_symbol = buf[index].
    - cursor_left = (cursor == index).
    - cursor_right = (index == length-1 && cursor == length).
  - ISSUE: symbol_drawer_start = (state==ISSUE && symbol_drawer_ready), combinational. When start=1, go to WAIT. Otherwise stay in ISSUE until the drawer is ready.
  - WAIT: when symbol_drawer_ready=1, do one of:
    - if index == length-1: pulse line_done (registered, the cycle after) and go to IDLE;
    - else: index+1 and go to LOAD.
- Operand outputs hold their value from LOAD until the next LOAD. Cursor flags do too. Operands keep their last value in IDLE.
- line_start outside IDLE is ignored, with no queueing.
- Reset values:
  - state=IDLE, line_ready=1, line_done=0, symbol_drawer_start=0.
  - x/y/symbol=0, cursor flags=0.
  - index=0, command registers=0.
- Reset mid-line:
  - The FSM returns to IDLE immediately and symbol_drawer_start drops asynchronously.
  - A drawer job already in flight is not cancelled.
  - The next line's first ISSUE waits for symbol_drawer_ready, so no job is started over a busy drawer.

## Timing

- Line command in IDLE at edge 0 -> LOAD in cycle 1 -> ISSUE in cycle 2. symbol_drawer_start is high in cycle 2 if the drawer is ready.
- Per glyph: LOAD 1 cycle + ISSUE ≥1 cycle + WAIT until drawer ready.
- If the drawer re-raises ready in cycle k, the next LOAD is in cycle k+1.
- line_done is high exactly 1 cycle, the cycle after WAIT sees ready for the last glyph; line_ready rises in that same cycle.
- Zero-length command: line_done is high the cycle after line_start, and line_ready never drops.
- A line_start arriving in the same cycle as line_done/line_ready rising is accepted.
- Simultaneous buffer write and LOAD read of the same index returns the old data.

## Test plan

- Buffer [0x41,0x42,0x43], line_x=100, line_y=20, length=3, cursor=1; drawer model busy 5 cycles per job. Required: three start pulses with x=100/108/116, y=20, symbols 0x41/0x42/0x43, cursor_left only on glyph 1, cursor_right never; exactly one line_done after the third job.
- Length=2, cursor=2. Required: glyph 1 has cursor_right=1 and cursor_left=0; glyph 0 has neither flag.
- line_x=0xFFFC, length=2. Required: x=0xFFFC, then 0x0004 (wrap). Length=0. Required: no start pulse, line_done the cycle after line_start, line_ready stays 1.
- Drawer ready held low at command time. Required: FSM stays in ISSUE with start=0 until ready rises, then exactly one start. A second line_start mid-line is ignored and does not produce a second line_done.
- Assert rst during WAIT of glyph 1 while the drawer is busy. Required: all outputs at reset values at once. A new command waits for drawer ready before its first start.
- Write buf[2]=0x5A while glyph 0 is in WAIT. Required: glyph 2 draws 0x5A. Length=MAX_LENGTH+1 (i.e. 33). Required: clamped to 32 jobs.
